// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the memory-address sequencer.
// Optional feature macro: MEM_ALIGN_CHECK_EN (alignment fault detection).
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Byte accesses are always aligned; the reserved size code behaves as a word.
  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_addr_seq_if.sv
// Control-unit <-> address sequencer bundle: source selection, request
// qualifiers and the registered access status coming back.
interface mem_addr_seq_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 6,
  parameter int SELW  = 3
);
  logic [SELW-1:0]       sel;
  logic [NSRC*WIDTH-1:0] src_flat;
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic [WIDTH-1:0]      addr_out;
  logic                  mem_wr;
  logic                  busy;
  logic                  done;
  logic                  misalign;

  // Control unit side.
  modport master (
    output sel, src_flat, req, we, size,
    input  addr_out, mem_wr, busy, done, misalign
  );

  // Sequencer side.
  modport slave (
    input  sel, src_flat, req, we, size,
    output addr_out, mem_wr, busy, done, misalign
  );
endinterface

// File: rtl/mux_n.sv
// Combinational N:1 address source selector; a selector value with no
// matching source yields an all-zero address.
module mux_n #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 6,
  parameter int SELW  = 3
) (
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] in_flat,
  output logic [WIDTH-1:0]      y
);

  logic [WIDTH-1:0] src_arr [NSRC];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign src_arr[gi] = in_flat[gi*WIDTH +: WIDTH];
  end

  // Pick the matching source; out-of-range selectors fall through to zero.
  always_comb begin
    y = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i)) y = src_arr[i];
    end
  end

endmodule

// File: rtl/mem_addr_seq.sv
// Memory address sequencer: captures one of NSRC address sources on req,
// holds it for a fixed-latency access and reports busy/done.
// Optional feature macro: MEM_ALIGN_CHECK_EN adds an alignment check at
// capture, a one-cycle FAULT state and the misalign pulse; without it
// misalign is tied low and every access completes with done.
module mem_addr_seq
  import mem_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 6,
  parameter int SELW    = 3,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_addr_seq_if.slave bus
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_e           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             we_reg, we_next;
  logic [WIDTH-1:0] addr_reg, addr_next;
  logic             busy_reg, mem_wr_reg, done_reg;
  logic [WIDTH-1:0] sel_addr;
  logic             capture_fault;

  mux_n #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_mux (
    .sel     (bus.sel),
    .in_flat (bus.src_flat),
    .y       (sel_addr)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign capture_fault = !is_aligned(sel_addr[1:0], bus.size);
`else
  assign capture_fault = 1'b0;
`endif

  // Next-state logic: inputs only matter in IDLE, everything else is timed.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          addr_next = sel_addr;
          we_next   = bus.we;
          cnt_next  = LAT;
          if (capture_fault)   state_next = FAULT;
          else if (LAT == 4'd0) state_next = DONE;
          else                  state_next = WAIT;
        end
      end
      WAIT: begin
        // A zero count here is unreachable; treat it as the last wait cycle.
        if (cnt_reg <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, captured access and status outputs; status is derived from the
  // next state so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      busy_reg   <= 1'b0;
      mem_wr_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      busy_reg   <= (state_next == WAIT);
      mem_wr_reg <= (state_next == WAIT) && we_next;
      done_reg   <= (state_next == DONE);
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_reg;

  // Fault pulse, registered from the next state like the other status bits.
  always_ff @(posedge clk) begin
    if (reset) misalign_reg <= 1'b0;
    else       misalign_reg <= (state_next == FAULT);
  end

  assign bus.misalign = misalign_reg;
`else
  assign bus.misalign = 1'b0;
`endif

  assign bus.addr_out = addr_reg;
  assign bus.mem_wr   = mem_wr_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Bench for mem_addr_seq: three instances (MEM_LAT 1, 3, 0) driven from a
// vector table, with expected completions queued at request time and
// checked when the access finishes; plus a mid-access reset sequence.
module tb_mem_addr_seq;
  import mem_seq_pkg::*;

  localparam int WIDTH = 32;
  localparam int NSRC  = 6;
  localparam int SELW  = 3;
  localparam int FW    = NSRC * WIDTH;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_addr_seq_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus_a ();
  mem_addr_seq_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus_b ();
  mem_addr_seq_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus_c ();

  mem_addr_seq #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  mem_addr_seq #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  mem_addr_seq #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .MEM_LAT(0)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  int lat_of [3] = '{1, 3, 0};

  typedef struct {
    int          d;
    logic [2:0]  sel;
    logic [31:0] src;
    logic        we;
    logic [1:0]  size;
    logic [31:0] exp_addr;
    logic        bad_align;
    logic        scramble;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          busy_n;
    int          wr_n;
    int          done_at;
    int          mis_at;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] make_flat(input logic [2:0] sel, input logic [31:0] src);
    logic [FW-1:0] f;
    int s;
    s = int'(sel);
    for (int k = 0; k < NSRC; k++) f[k*WIDTH +: WIDTH] = $urandom() | 32'h0001_0000;
    if (s < NSRC) f[s*WIDTH +: WIDTH] = src;
    return f;
  endfunction

  task automatic drive(input int d, input logic r, input logic [2:0] s, input logic w,
                       input logic [1:0] sz, input logic [FW-1:0] f);
    case (d)
      0: begin bus_a.req = r; bus_a.sel = s; bus_a.we = w; bus_a.size = sz; bus_a.src_flat = f; end
      1: begin bus_b.req = r; bus_b.sel = s; bus_b.we = w; bus_b.size = sz; bus_b.src_flat = f; end
      default: begin bus_c.req = r; bus_c.sel = s; bus_c.we = w; bus_c.size = sz; bus_c.src_flat = f; end
    endcase
  endtask

  task automatic sample(input int d, output logic [31:0] a, output logic wr,
                        output logic b, output logic dn, output logic mis);
    case (d)
      0: begin a = bus_a.addr_out; wr = bus_a.mem_wr; b = bus_a.busy; dn = bus_a.done; mis = bus_a.misalign; end
      1: begin a = bus_b.addr_out; wr = bus_b.mem_wr; b = bus_b.busy; dn = bus_b.done; mis = bus_b.misalign; end
      default: begin a = bus_c.addr_out; wr = bus_c.mem_wr; b = bus_c.busy; dn = bus_c.done; mis = bus_c.misalign; end
    endcase
  endtask

  // Watch one access from the cycle after capture until done/misalign, then
  // one more cycle to confirm the pulse ended and no request slipped in.
  task automatic collect(input int idx, input vec_t v, input logic [FW-1:0] f);
    exp_t e;
    logic [31:0] a;
    logic wr, b, dn, mis, addr_ok;
    int busy_n, wr_n, done_at, mis_at;
    e = sb_q.pop_front();
    addr_ok = 1'b1; busy_n = 0; wr_n = 0; done_at = -1; mis_at = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      sample(v.d, a, wr, b, dn, mis);
      if (a !== e.addr) addr_ok = 1'b0;
      if (b === 1'b1) busy_n++;
      if (wr === 1'b1) wr_n++;
      if (v.scramble)
        drive(v.d, ($urandom_range(0, 1) == 1) || (dn === 1'b1), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), make_flat(3'd0, $urandom()));
      else
        drive(v.d, 1'b0, v.sel, v.we, v.size, f);
      if (dn === 1'b1) begin done_at = i; break; end
      if (mis === 1'b1) begin mis_at = i; break; end
    end
    @(negedge clk);
    sample(v.d, a, wr, b, dn, mis);
    if (a !== e.addr) addr_ok = 1'b0;
    drive(v.d, 1'b0, v.sel, v.we, v.size, f);
    $display("vec %0d dut%0d sel=%0d addr=%h busy_cycles=%0d wr_cycles=%0d done_at=%0d misalign_at=%0d",
             idx, v.d, v.sel, a, busy_n, wr_n, done_at, mis_at);
    check($sformatf("v%0d addr_stable", idx), 32'(addr_ok), 32'd1);
    check($sformatf("v%0d busy_cycles", idx), 32'(busy_n), 32'(e.busy_n));
    check($sformatf("v%0d wr_cycles", idx), 32'(wr_n), 32'(e.wr_n));
    check($sformatf("v%0d done_at", idx), 32'(done_at), 32'(e.done_at));
    check($sformatf("v%0d misalign_at", idx), 32'(mis_at), 32'(e.mis_at));
    check($sformatf("v%0d after_idle", idx), {29'd0, b, dn, mis}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    logic [FW-1:0] f;
    logic fault;
    f = make_flat(v.sel, v.src);
    fault = v.bad_align && ALIGN_ON;
    e.addr    = v.exp_addr;
    e.busy_n  = fault ? 0 : lat_of[v.d];
    e.wr_n    = (fault || !v.we) ? 0 : lat_of[v.d];
    e.done_at = fault ? -1 : lat_of[v.d] + 1;
    e.mis_at  = fault ? 1 : -1;
    sb_q.push_back(e);
    drive(v.d, 1'b1, v.sel, v.we, v.size, f);
    collect(idx, v, f);
  endtask

  initial begin
    vec_t vt [12];
    logic [31:0] a;
    logic wr, b, dn, mis, seen_done;
    logic [FW-1:0] f;

    vt[0]  = '{0, 3'd1, 32'h0000_0100, 1'b0, SZ_WORD, 32'h0000_0100, 1'b0, 1'b0};
    vt[1]  = '{1, 3'd3, 32'h0000_2000, 1'b1, SZ_WORD, 32'h0000_2000, 1'b0, 1'b0};
    vt[2]  = '{2, 3'd2, 32'h0000_3000, 1'b1, SZ_WORD, 32'h0000_3000, 1'b0, 1'b0};
    vt[3]  = '{0, 3'd7, 32'hDEAD_BEE0, 1'b1, SZ_WORD, 32'h0000_0000, 1'b0, 1'b0};
    vt[4]  = '{0, 3'd5, 32'hFFFF_FFFC, 1'b1, SZ_WORD, 32'hFFFF_FFFC, 1'b0, 1'b0};
    vt[5]  = '{1, 3'd0, 32'h0000_0044, 1'b1, SZ_BYTE, 32'h0000_0044, 1'b0, 1'b1};
    vt[6]  = '{0, 3'd2, 32'h0000_0102, 1'b1, SZ_WORD, 32'h0000_0102, 1'b1, 1'b0};
    vt[7]  = '{0, 3'd2, 32'h0000_0102, 1'b1, SZ_HALF, 32'h0000_0102, 1'b0, 1'b0};
    vt[8]  = '{2, 3'd4, 32'h0000_0103, 1'b0, SZ_BYTE, 32'h0000_0103, 1'b0, 1'b0};
    vt[9]  = '{1, 3'd1, 32'h0000_0106, 1'b1, 2'b11,   32'h0000_0106, 1'b1, 1'b0};
    vt[10] = '{2, 3'd3, 32'h0000_0101, 1'b1, SZ_HALF, 32'h0000_0101, 1'b1, 1'b0};
    vt[11] = '{1, 3'd6, 32'h1234_5678, 1'b1, SZ_WORD, 32'h0000_0000, 1'b0, 1'b0};

    for (int d = 0; d < 3; d++) drive(d, 1'b0, 3'd0, 1'b0, SZ_WORD, '0);

    // Reset state of every instance.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sample(d, a, wr, b, dn, mis);
      check($sformatf("reset_addr dut%0d", d), a, 32'd0);
      check($sformatf("reset_flags dut%0d", d), {28'd0, wr, b, dn, mis}, 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

    // Reset in the middle of a write wait on the MEM_LAT=3 instance.
    f = make_flat(3'd3, 32'h0000_5000);
    drive(1, 1'b1, 3'd3, 1'b1, SZ_WORD, f);
    @(negedge clk);
    drive(1, 1'b0, 3'd3, 1'b1, SZ_WORD, f);
    sample(1, a, wr, b, dn, mis);
    check("rst_mid busy", 32'(b), 32'd1);
    check("rst_mid addr", a, 32'h0000_5000);
    @(negedge clk);
    sample(1, a, wr, b, dn, mis);
    check("rst_mid mem_wr", 32'(wr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sample(1, a, wr, b, dn, mis);
    $display("reset mid-access: addr=%h mem_wr=%0d busy=%0d done=%0d", a, wr, b, dn);
    check("rst_after addr", a, 32'd0);
    check("rst_after flags", {28'd0, wr, b, dn, mis}, 32'd0);
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sample(1, a, wr, b, dn, mis);
      if (dn === 1'b1 || b === 1'b1) seen_done = 1'b1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);

    // The instance recovers and serves a normal access after reset.
    run_vec(12, vt[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "time limit");
  end

endmodule
